// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants and GF(2^8) helpers
package aes_pkg;

   // number of rounds for AES-128
   localparam logic [3:0] NR = 4'd10;

   // multiply by x in GF(2^8), reduced by the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // round constant for rounds 1..10; anything else yields zero
   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // LSB position of byte s(r,c) in a 128-bit column-major state
   function automatic int byte_lsb(input int r, input int c);
      return 120 - 8 * (4 * c + r);
   endfunction

endpackage

// File: rtl/aes_round_key_mix_if.sv
// rtl/aes_round_key_mix_if.sv - key/state bus of the round tail
interface aes_round_key_mix_if;
   logic         key_load;
   logic [127:0] key;
   logic         in_valid;
   logic [127:0] state_in;
   logic         out_valid;
   logic [127:0] state_out;
   logic [3:0]   round_idx;
   logic [127:0] round_key;
   logic         done;

   modport master (
      output key_load, key, in_valid, state_in,
      input  out_valid, state_out, round_idx, round_key, done
   );

   modport slave (
      input  key_load, key, in_valid, state_in,
      output out_valid, state_out, round_idx, round_key, done
   );
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   // entry 0 sits in the top byte, so entry n lives at bit offset 8*(255-n)
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [10:0] bit_ofs;

   // 8*(255-n) is simply the inverted index shifted left by three
   assign bit_ofs  = {~in_byte, 3'b000};
   assign out_byte = SBOX[bit_ofs +: 8];
endmodule

// File: rtl/aes_round_key_mix.sv
// rtl/aes_round_key_mix.sv - AES-128 round tail: key expansion, MixColumns, AddRoundKey
module aes_round_key_mix
   import aes_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   aes_round_key_mix_if.slave  bus
);
   logic [127:0] round_key_q, round_key_d;
   logic [3:0]   round_idx_q, round_idx_d;
   logic [127:0] state_out_q, state_out_d;
   logic         out_valid_q, out_valid_d;
   logic         done_q, done_d;

   logic [31:0]  w0, w1, w2, w3, rot_w3, sub_word, t_word;
   logic [31:0]  n0, n1, n2, n3;
   logic [127:0] next_key;
   logic [127:0] mixed;

   assign w0     = round_key_q[127:96];
   assign w1     = round_key_q[95:64];
   assign w2     = round_key_q[63:32];
   assign w3     = round_key_q[31:0];
   assign rot_w3 = {w3[23:0], w3[31:24]};

   aes_sbox u_sbox0 (.in_byte(rot_w3[31:24]), .out_byte(sub_word[31:24]));
   aes_sbox u_sbox1 (.in_byte(rot_w3[23:16]), .out_byte(sub_word[23:16]));
   aes_sbox u_sbox2 (.in_byte(rot_w3[15:8]),  .out_byte(sub_word[15:8]));
   aes_sbox u_sbox3 (.in_byte(rot_w3[7:0]),   .out_byte(sub_word[7:0]));

   // derive the key for the following round from the current one
   always_comb begin
      t_word   = sub_word ^ {rcon(round_idx_q + 4'd1), 24'h000000};
      n0       = w0 ^ t_word;
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   // MixColumns on the incoming state, one column at a time
   always_comb begin
      logic [7:0] a0, a1, a2, a3;
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = bus.state_in[byte_lsb(0, c) +: 8];
         a1 = bus.state_in[byte_lsb(1, c) +: 8];
         a2 = bus.state_in[byte_lsb(2, c) +: 8];
         a3 = bus.state_in[byte_lsb(3, c) +: 8];
         mixed[byte_lsb(0, c) +: 8] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
         mixed[byte_lsb(1, c) +: 8] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
         mixed[byte_lsb(2, c) +: 8] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
         mixed[byte_lsb(3, c) +: 8] = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
      end
   end

   // key_load restarts the schedule; a round step runs only while not done
   always_comb begin
      round_key_d = round_key_q;
      round_idx_d = round_idx_q;
      state_out_d = state_out_q;
      done_d      = done_q;
      out_valid_d = 1'b0;
      if (bus.key_load) begin
         round_key_d = bus.key;
         round_idx_d = 4'd0;
         done_d      = 1'b0;
      end else if (bus.in_valid && (round_idx_q <= NR)) begin
         // first and last rounds skip MixColumns
         if ((round_idx_q == 4'd0) || (round_idx_q == NR)) begin
            state_out_d = bus.state_in ^ round_key_q;
         end else begin
            state_out_d = mixed ^ round_key_q;
         end
         out_valid_d = 1'b1;
         round_key_d = next_key;
         round_idx_d = round_idx_q + 4'd1;
         if (round_idx_q == NR) begin
            done_d = 1'b1;
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         round_key_q <= '0;
         round_idx_q <= '0;
         state_out_q <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         round_key_q <= round_key_d;
         round_idx_q <= round_idx_d;
         state_out_q <= state_out_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign bus.round_key = round_key_q;
   assign bus.round_idx = round_idx_q;
   assign bus.state_out = state_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_aes_round_key_mix.sv
// tb/tb_aes_round_key_mix.sv - randomized and directed bench with an AES reference model
module tb_aes_round_key_mix;
   logic clk;
   logic rst;

   aes_round_key_mix_if bus ();

   aes_round_key_mix dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;

   logic [7:0]   sbox_tab [256];
   logic [127:0] m_rk;
   int           m_idx;
   logic         m_done;
   logic         m_ov;
   logic [127:0] m_out;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] w;
      w = {x, x} << n;
      return w[15:8];
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [7:0] get_b(input logic [127:0] s, input int r, input int c);
      return s[127 - 8 * (4 * c + r) -: 8];
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   m [4];
      logic [7:0]   acc;
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - r + 4) % 4], get_b(s, k, c));
            o[127 - 8 * (4 * c + r) -: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] ref_next_key(input logic [127:0] k, input int rnd);
      logic [31:0] w [4];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 1; i < rnd; i++) rc = gmul(rc, 8'h02);
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
      t = {sbox_tab[w[3][23:16]], sbox_tab[w[3][15:8]], sbox_tab[w[3][7:0]], sbox_tab[w[3][31:24]]};
      t = t ^ {rc, 24'h0};
      w[0] = w[0] ^ t;
      for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i - 1];
      return {w[0], w[1], w[2], w[3]};
   endfunction

   task automatic model_step(input logic r, input logic kl, input logic [127:0] k,
                             input logic iv, input logic [127:0] si);
      if (r) begin
         m_rk = '0; m_idx = 0; m_done = 0; m_ov = 0; m_out = '0;
      end else if (kl) begin
         m_rk = k; m_idx = 0; m_done = 0; m_ov = 0;
      end else if (iv && m_idx <= 10) begin
         if (m_idx == 0 || m_idx == 10) m_out = si ^ m_rk;
         else m_out = ref_mix(si) ^ m_rk;
         if (m_idx == 10) m_done = 1;
         m_ov = 1;
         m_rk = ref_next_key(m_rk, m_idx + 1);
         m_idx = m_idx + 1;
      end else begin
         m_ov = 0;
      end
   endtask

   // one clock: drive, advance model, sample one time unit after the edge
   task automatic cycle(input logic r, input logic kl, input logic [127:0] k,
                        input logic iv, input logic [127:0] si);
      rst          = r;
      bus.key_load = kl;
      bus.key      = k;
      bus.in_valid = iv;
      bus.state_in = si;
      model_step(r, kl, k, iv, si);
      @(posedge clk);
      #1;
      check_eq("out_valid", {127'b0, bus.out_valid}, {127'b0, m_ov});
      check_eq("state_out", bus.state_out, m_out);
      check_eq("round_idx", {124'b0, bus.round_idx}, 128'(m_idx));
      check_eq("done", {127'b0, bus.done}, {127'b0, m_done});
      if (!m_done) check_eq("round_key", bus.round_key, m_rk);
      rst          = 1'b0;
      bus.key_load = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      logic [127:0] col4;
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.key_load = 1'b0;
      bus.key = '0;
      bus.in_valid = 1'b0;
      bus.state_in = '0;
      build_sbox();
      check_eq("sbox_model_00", {120'b0, sbox_tab[0]}, 128'h63);
      check_eq("sbox_model_53", {120'b0, sbox_tab[8'h53]}, 128'hed);

      // reset state
      cycle(1, 0, '0, 0, '0);
      check_eq("rst_state_out", bus.state_out, 128'h0);
      check_eq("rst_round_key", bus.round_key, 128'h0);

      // FIPS-197 rounds 0 and 1
      cycle(0, 1, FIPS_KEY, 0, '0);
      cycle(0, 0, '0, 1, 128'h3243f6a8885a308d313198a2e0370734);
      check_eq("fips_r0_out", bus.state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      check_eq("fips_rk1", bus.round_key, 128'ha0fafe1788542cb123a339392a6c7605);
      cycle(0, 0, '0, 1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
      check_eq("fips_r1_out", bus.state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);

      // full key schedule with zero state
      cycle(0, 1, FIPS_KEY, 0, '0);
      for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1, '0);
      check_eq("rk10", bus.round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_eq("idx10", {124'b0, bus.round_idx}, 128'd10);
      cycle(0, 0, '0, 1, '0);
      check_eq("r10_out", bus.state_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_eq("r10_done", {127'b0, bus.done}, 128'd1);
      cycle(0, 0, '0, 1, 128'h1234);
      check_eq("after_done_ov", {127'b0, bus.out_valid}, 128'd0);
      check_eq("after_done_out", bus.state_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_eq("after_done_idx", {124'b0, bus.round_idx}, 128'd11);

      // MixColumns with zero key
      cycle(0, 1, '0, 0, '0);
      cycle(0, 0, '0, 1, '0);
      col4 = {4{32'hdb135345}};
      cycle(0, 0, '0, 1, col4);
      check_eq("mixcol_out", bus.state_out, {4{32'hec2ec2df}});

      // key_load and in_valid together
      cycle(0, 1, 128'hcafef00d, 1, 128'h55);
      check_eq("collide_ov", {127'b0, bus.out_valid}, 128'd0);
      check_eq("collide_rk", bus.round_key, 128'hcafef00d);

      // reset mid-sequence
      cycle(0, 1, FIPS_KEY, 0, '0);
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, {$urandom, $urandom, $urandom, $urandom});
      cycle(1, 0, '0, 0, '0);
      check_eq("midrst_idx", {124'b0, bus.round_idx}, 128'd0);
      col4 = {$urandom, $urandom, $urandom, $urandom};
      cycle(0, 0, '0, 1, col4);
      check_eq("post_rst_out", bus.state_out, col4);

      // randomized traffic
      for (int blk = 0; blk < 12; blk++) begin
         cycle(0, 1, {$urandom, $urandom, $urandom, $urandom}, 0, '0);
         for (int i = 0; i < 16; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
                  {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 99) < 75), {$urandom, $urandom, $urandom, $urandom});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_round_key_mix.md
Name: aes_round_key_mix

Overview:
- Iterative AES-128 encryption round tail: on-the-fly KeyExpansion plus MixColumns and AddRoundKey.
- Consumes one 128-bit state per step and returns the state XORed with the current round key; MixColumns is applied on rounds 1-9.
- Sits after the SubBytes/ShiftRows stage in the round loop of the AES core; round keys are generated internally, one per step, from a loaded cipher key.

Parameters:
- none (AES-128 only: Nk=4, Nr=10, fixed)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_load  in  1  pulse; latch key, restart at round 0
- key  in  128  cipher key; word w0 = key[127:96]
- in_valid  in  1  pulse; state_in is valid this cycle
- state_in  in  128  state; byte s(r,c) = state_in[127-8*(4c+r) -: 8] (FIPS-197 column-major)
- out_valid  out  1  state_out valid (one-cycle pulse)
- state_out  out  128  round result
- round_idx  out  4  round number the next in_valid will use (0..10; 11 = done)
- round_key  out  128  round key the next in_valid will use
- done  out  1  high after round 10 completes, until key_load or rst

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, state_out=0, round_idx=0, round_key=0, done=0. Reset has priority over every other input.
- key_load=1: round_key<=key, round_idx<=0, done<=0, out_valid<=0.
  - An in_valid in the same cycle is dropped.
- in_valid=1 with round_idx=r, r<=10, and no key_load:
  - r=0: state_out <= state_in ^ round_key.
  - 1<=r<=9: state_out <= MixColumns(state_in) ^ round_key.
  - r=10: state_out <= state_in ^ round_key; done<=1.
  - out_valid<=1 for exactly one cycle, so latency is 1 clk.
  - round_key<=next_key(round_key, rcon[r+1]); round_idx<=r+1.
- in_valid while done=1 (round_idx=11): ignored. Outputs hold, out_valid=0, round_key is not advanced.
- in_valid=0: out_valid<=0; state_out holds its last value.
- next_key: words w0..w3 of the current key.
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- MixColumns, per column [a0..a3]:
  - b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
  - Arithmetic is in GF(2^8) with xtime reduction by 8'h1b.
- All datapath logic is combinational from registers and inputs. Only round_key, round_idx, state_out, out_valid and done are registered.
- Back-to-back in_valid on consecutive cycles is supported: 11 consecutive pulses complete a block.

Decomposition:
- Shared package aes_pkg:
  - rcon table function.
  - xtime/gf_mul2/gf_mul3 functions.
  - 128-bit state byte-index helper.
  - NR=10 constant.
- Sub-module aes_sbox: a 256-entry combinational S-box lookup, instantiated 4 times for SubWord. It is shared with the SubBytes stage.

Test Plan:
- Reset: assert rst mid-sequence (after 3 rounds) -> next cycle all outputs 0, round_idx=0; a subsequent in_valid without key_load yields state_in ^ 0.
- Round 0, key=2b7e151628aed2a6abf7158809cf4f3c:
  - Load key and apply state_in=3243f6a8885a308d313198a2e0370734 -> state_out=193de3bea0f4e22b9ac68d2ae9f84808 one clk later.
  - round_key then = a0fafe1788542cb123a339392a6c7605.
- Round 1, same key: in_valid with state_in=d4bf5d30e0b452aeb84111f11e2798e5 -> state_out=a49c7ff2689f352b6b5bea43026a5049.
- Key schedule: 10 in_valid pulses with state_in=0 after loading the same key -> round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, round_idx=10.
  - An 11th pulse with state_in=0 gives state_out=d014f9a8c9ee2589e13f0cc8b6630ca6 and done=1.
  - A 12th pulse gives out_valid=0 and no change.
- MixColumns, key=0, round 1 (key schedule makes rk1=62636363 x4):
  - Apply column db135345 in all 4 columns -> each output column = 8e4da1bc ^ 62636363 = ec2ec2df.
- Collision: key_load and in_valid in the same cycle -> out_valid stays 0, round_idx=0, round_key=new key.
